// File: rtl/spike_pkt_tx_if.sv
// Spike transmitter bus: fire-side push handshake plus Mem packet-in side.
// Master is the neuron array / Mem environment; slave is the transmitter.
interface spike_pkt_tx_if #(
  parameter int ID_Width = 4
);
  logic                Fire_Valid;
  logic [ID_Width-1:0] Fire_ID;
  logic                Fire_Ready;
  logic                Mem_Ready;
  logic [2:0]          MODE;
  logic [ID_Width-1:0] PacketID_Out;
  logic                Pkt_Valid;

  modport master (
    output Fire_Valid, Fire_ID, Mem_Ready,
    input  Fire_Ready, MODE, PacketID_Out, Pkt_Valid
  );

  modport slave (
    input  Fire_Valid, Fire_ID, Mem_Ready,
    output Fire_Ready, MODE, PacketID_Out, Pkt_Valid
  );
endinterface

// File: rtl/spike_pkt_tx.sv
// Spike packet transmitter: FIFO of fired IDs issued to Mem in MODE_F.
// Optional SPIKE_TX_STATS_EN adds a saturating Tx_Count of issued packets.
module spike_pkt_tx #(
  parameter int ID_Width    = 4,
  parameter int FIFO_AW     = 3,
  parameter int FIRE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spike_pkt_tx_if.slave      bus,
  input  logic               Flush,
  output logic [FIFO_AW:0]   Fifo_Count,
  output logic               Busy
`ifdef SPIKE_TX_STATS_EN
  ,
  output logic [15:0]        Tx_Count
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int HW    = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(FIRE_CYCLES - 1);
  localparam logic [2:0] MODE_I = 3'b000;
  localparam logic [2:0] MODE_F = 3'b011;

  typedef enum logic {IDLE, FIRE} state_t;

  logic [ID_Width-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                full, push, pop, can_pop;

  state_t              state, state_n;
  logic [HW-1:0]       hold, hold_n;
  logic [2:0]          mode_q, mode_n;
  logic [ID_Width-1:0] pid_q, pid_n;
  logic                pv_q, pv_n;

  assign full           = (count == CW'(DEPTH));
  assign bus.Fire_Ready = rst_n & ~full & ~Flush;
  assign push           = bus.Fire_Valid & bus.Fire_Ready;
  assign can_pop        = (count != '0) & bus.Mem_Ready & ~Flush;

  // FIFO storage; contents need no reset, pointers gate validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.Fire_ID;
  end

  // FIFO pointers and occupancy; flush discards everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Issue FSM: pop head, hold it FIRE_CYCLES, chain back-to-back
  always_comb begin
    state_n = state;
    hold_n  = hold;
    pop     = 1'b0;
    mode_n  = mode_q;
    pid_n   = pid_q;
    pv_n    = pv_q;
    unique case (state)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          pid_n   = mem[rd_ptr];
          mode_n  = MODE_F;
          pv_n    = 1'b1;
          hold_n  = HOLD_INIT;
          state_n = FIRE;
        end
      end
      FIRE: begin
        if (hold != '0) begin
          hold_n = hold - HW'(1);
        end else if (can_pop) begin
          pop    = 1'b1;
          pid_n  = mem[rd_ptr];
          hold_n = HOLD_INIT;
        end else begin
          mode_n  = MODE_I;
          pv_n    = 1'b0;
          state_n = IDLE;
        end
      end
    endcase
  end

  // FSM state and registered Mem-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold   <= '0;
      mode_q <= MODE_I;
      pid_q  <= '0;
      pv_q   <= 1'b0;
    end else begin
      state  <= state_n;
      hold   <= hold_n;
      mode_q <= mode_n;
      pid_q  <= pid_n;
      pv_q   <= pv_n;
    end
  end

  assign bus.MODE         = mode_q;
  assign bus.PacketID_Out = pid_q;
  assign bus.Pkt_Valid    = pv_q;
  assign Fifo_Count       = count;
  assign Busy             = pv_q | (count != '0);

`ifdef SPIKE_TX_STATS_EN
  logic [15:0] tx_cnt;

  // Count issued packets, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
    end else if (pop && tx_cnt != 16'hFFFF) begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign Tx_Count = tx_cnt;
`endif

endmodule

// File: tb/tb_spike_pkt_tx.sv
// Bench for spike_pkt_tx: scoreboard queue of pushed IDs checked
// against every issued packet, plus directed reset/latency/stall/flush cases.
module tb_spike_pkt_tx;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Flush = 1'b0;
  logic [3:0] Fifo_Count;
  logic       Busy;
`ifdef SPIKE_TX_STATS_EN
  logic [15:0] Tx_Count;
`endif

  spike_pkt_tx_if #(.ID_Width(4)) bus ();

  spike_pkt_tx #(
    .ID_Width(4),
    .FIFO_AW(3),
    .FIRE_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .Flush(Flush),
    .Fifo_Count(Fifo_Count),
    .Busy(Busy)
`ifdef SPIKE_TX_STATS_EN
    ,
    .Tx_Count(Tx_Count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] q[$];
  bit         m_pv = 0;
  logic [3:0] m_id = '0;
  int         m_left = 0;
  int         m_tx = 0;
  bit         mon_en = 0;
  bit         saw_a = 0;
  bit         saw_full = 0;
  bit         rdy, psh;

  // Compare this cycle against the model, then advance the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("pkt_valid", 32'(bus.Pkt_Valid), 32'(m_pv));
      check("mode", 32'(bus.MODE), m_pv ? 32'd3 : 32'd0);
      check("pkt_id", 32'(bus.PacketID_Out), 32'(m_id));
      check("fifo_count", 32'(Fifo_Count), q.size());
      check("busy", 32'(Busy), 32'(m_pv || q.size() != 0));
      rdy = (q.size() < 8) && !Flush;
      check("fire_ready", 32'(bus.Fire_Ready), 32'(rdy));
`ifdef SPIKE_TX_STATS_EN
      check("tx_count", 32'(Tx_Count), m_tx);
`endif
      if (bus.Pkt_Valid && bus.PacketID_Out == 4'hA) saw_a = 1;
      if (q.size() == 8) saw_full = 1;
      psh = bus.Fire_Valid && rdy;
      if (m_pv && m_left > 0) begin
        m_left--;
      end else if (q.size() != 0 && bus.Mem_Ready && !Flush) begin
        m_id   = q.pop_front();
        m_pv   = 1;
        m_left = FC - 1;
        if (m_tx < 65535) m_tx++;
      end else begin
        m_pv = 0;
      end
      if (Flush) q.delete();
      else if (psh) q.push_back(bus.Fire_ID);
    end
  end

  task automatic push_id(input logic [3:0] id);
    int n = 0;
    bus.Fire_ID    = id;
    bus.Fire_Valid = 1'b1;
    @(negedge clk);
    while (!bus.Fire_Ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.Fire_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Fire_Valid = 1'b0;
    bus.Fire_ID    = '0;
    bus.Mem_Ready  = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    check("rst_mode", 32'(bus.MODE), 32'd0);
    check("rst_valid", 32'(bus.Pkt_Valid), 32'd0);
    check("rst_count", 32'(Fifo_Count), 32'd0);
    check("rst_ready", 32'(bus.Fire_Ready), 32'd0);
    check("rst_id", 32'(bus.PacketID_Out), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(bus.Fire_Ready), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1;
    bus.Mem_Ready = 1'b1;

    // single packet latency
    push_id(4'h5);
    @(negedge clk);
    check("single_c1_valid", 32'(bus.Pkt_Valid), 32'd0);
    @(negedge clk);
    check("single_c2_id", 32'(bus.PacketID_Out), 32'h5);
    check("single_c2_mode", 32'(bus.MODE), 32'd3);
    @(negedge clk);
    check("single_c3_valid", 32'(bus.Pkt_Valid), 32'd1);
    @(negedge clk);
    check("single_c4_mode", 32'(bus.MODE), 32'd0);
    wait_idle();

    // burst 0..9
    for (int i = 0; i < 10; i++) push_id(4'(i));
    wait_idle();

    // stall on Mem_Ready
    bus.Mem_Ready = 1'b0;
    push_id(4'h3);
    push_id(4'h7);
    push_id(4'h9);
    @(negedge clk);
    check("stall_count", 32'(Fifo_Count), 32'd3);
    check("stall_mode", 32'(bus.MODE), 32'd0);
    @(posedge clk);
    #1;
    bus.Mem_Ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_first_id", 32'(bus.PacketID_Out), 32'h3);
    check("stall_first_valid", 32'(bus.Pkt_Valid), 32'd1);
    wait_idle();

    // fill to full, then push against a simultaneous pop
    bus.Mem_Ready = 1'b0;
    for (int i = 0; i < 8; i++) push_id(4'(i));
    bus.Fire_ID    = 4'h8;
    bus.Fire_Valid = 1'b1;
    repeat (2) @(negedge clk);
    check("full_count", 32'(Fifo_Count), 32'd8);
    check("full_ready", 32'(bus.Fire_Ready), 32'd0);
    @(posedge clk);
    #1;
    bus.Mem_Ready = 1'b1;
    push_id(4'h8);
    wait_idle();

    // flush with one in flight and five queued
    bus.Mem_Ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_id(4'(i));
    bus.Mem_Ready = 1'b1;
    @(posedge clk);
    #1;
    Flush          = 1'b1;
    bus.Fire_Valid = 1'b1;
    bus.Fire_ID    = 4'hA;
    @(negedge clk);
    check("flush_pre_count", 32'(Fifo_Count), 32'd5);
    @(posedge clk);
    #1;
    Flush          = 1'b0;
    bus.Fire_Valid = 1'b0;
    @(negedge clk);
    check("flush_post_count", 32'(Fifo_Count), 32'd0);
    check("flush_inflight_id", 32'(bus.PacketID_Out), 32'h1);
    check("flush_inflight_v", 32'(bus.Pkt_Valid), 32'd1);
    wait_idle();
    check("a_never_issued", 32'(saw_a), 32'd0);
    check("saw_full", 32'(saw_full), 32'd1);
`ifdef SPIKE_TX_STATS_EN
    check("tx_total", 32'(Tx_Count), 32'd24);
`endif

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
